// File: rtl/terminal_writer_if.sv
// Character-input and VRAM-write handshakes plus scanner/cursor status
// of the terminal writer, bundled for port connection.
interface terminal_writer_if #(
  parameter int unsigned ROW_BITS = 5,
  parameter int unsigned COL_BITS = 7
);
  logic                character_ready;
  logic                character_valid;
  logic [7:0]          character_byte;
  logic                write_ready;
  logic                write_valid;
  logic [ROW_BITS-1:0] write_row;
  logic [COL_BITS-1:0] write_col;
  logic [7:0]          write_byte;
  logic [ROW_BITS-1:0] top_row;
  logic [ROW_BITS-1:0] cursor_row;
  logic [COL_BITS-1:0] cursor_col;

  // Writer side: consumes characters, produces VRAM writes and status.
  modport master (
    output character_ready,
    input  character_valid, character_byte,
    input  write_ready,
    output write_valid, write_row, write_col, write_byte,
    output top_row, cursor_row, cursor_col
  );

  // Environment side: character source, VRAM sink and scanner.
  modport slave (
    input  character_ready,
    output character_valid, character_byte,
    output write_ready,
    input  write_valid, write_row, write_col, write_byte,
    input  top_row, cursor_row, cursor_col
  );
endinterface

// File: rtl/terminal_writer.sv
// Text terminal writer: places glyphs in VRAM at a tracked cursor, handles
// CR/LF/BS/TAB, and scrolls by rotating a circular top_row pointer.
module terminal_writer #(
  parameter int unsigned ROWS      = 30,
  parameter int unsigned COLS      = 80,
  parameter int unsigned ROW_BITS  = 5,
  parameter int unsigned COL_BITS  = 7,
  parameter int unsigned TAB_WIDTH = 8,
  parameter logic [7:0]  BLANK     = 8'h20
) (
  input  logic clk,
  input  logic reset,
  terminal_writer_if.master bus
);

  typedef enum logic [1:0] {CLEAR_ALL, IDLE, WRITE, CLEAR_LINE} state_t;

  localparam logic [ROW_BITS-1:0] ROW_LAST = ROW_BITS'(ROWS - 1);
  localparam logic [COL_BITS-1:0] COL_LAST = COL_BITS'(COLS - 1);
  localparam logic [ROW_BITS:0]   ROWS_EXT = (ROW_BITS + 1)'(ROWS);

  state_t              state;
  logic [ROW_BITS:0]   phys_sum_c;
  logic [ROW_BITS-1:0] phys_row_c;
  logic [ROW_BITS-1:0] top_next_c;
  logic [31:0]         tab_next_c;
  logic [COL_BITS-1:0] tab_col_c;
  logic                accept_c;
  logic                printable_c;

  // Cursor-to-physical row mapping, circular top increment and tab stop.
  always_comb begin
    phys_sum_c = {1'b0, bus.top_row} + {1'b0, bus.cursor_row};
    if (phys_sum_c >= ROWS_EXT) begin
      phys_row_c = ROW_BITS'(phys_sum_c - ROWS_EXT);
    end else begin
      phys_row_c = phys_sum_c[ROW_BITS-1:0];
    end
    top_next_c  = (bus.top_row == ROW_LAST) ? '0 : bus.top_row + ROW_BITS'(1);
    tab_next_c  = (32'(bus.cursor_col) / TAB_WIDTH + 32'd1) * TAB_WIDTH;
    tab_col_c   = (tab_next_c > 32'(COLS - 1)) ? COL_LAST : COL_BITS'(tab_next_c);
    accept_c    = bus.character_valid && bus.character_ready;
    printable_c = (bus.character_byte >= 8'h20) && (bus.character_byte <= 8'h7E);
  end

  // Control FSM; every output is a register updated here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state               <= CLEAR_ALL;
      bus.character_ready <= 1'b0;
      bus.write_valid     <= 1'b0;
      bus.write_row       <= '0;
      bus.write_col       <= '0;
      bus.write_byte      <= BLANK;
      bus.top_row         <= '0;
      bus.cursor_row      <= '0;
      bus.cursor_col      <= '0;
    end else begin
      case (state)
        CLEAR_ALL: begin
          if (!bus.write_valid) begin
            bus.write_valid <= 1'b1;
            bus.write_row   <= '0;
            bus.write_col   <= '0;
            bus.write_byte  <= BLANK;
          end else if (bus.write_ready) begin
            if (bus.write_col == COL_LAST) begin
              bus.write_col <= '0;
              if (bus.write_row == ROW_LAST) begin
                bus.write_valid     <= 1'b0;
                bus.character_ready <= 1'b1;
                state               <= IDLE;
              end else begin
                bus.write_row <= bus.write_row + ROW_BITS'(1);
              end
            end else begin
              bus.write_col <= bus.write_col + COL_BITS'(1);
            end
          end
        end

        IDLE: begin
          if (accept_c) begin
            if (printable_c) begin
              bus.character_ready <= 1'b0;
              bus.write_valid     <= 1'b1;
              bus.write_row       <= phys_row_c;
              bus.write_col       <= bus.cursor_col;
              bus.write_byte      <= bus.character_byte;
              state               <= WRITE;
            end else begin
              case (bus.character_byte)
                8'h0D: bus.cursor_col <= '0;
                8'h0A: begin
                  if (bus.cursor_row != ROW_LAST) begin
                    bus.cursor_row <= bus.cursor_row + ROW_BITS'(1);
                  end else begin
                    // Old top line becomes the new bottom line and is blanked.
                    bus.top_row         <= top_next_c;
                    bus.character_ready <= 1'b0;
                    bus.write_valid     <= 1'b1;
                    bus.write_row       <= bus.top_row;
                    bus.write_col       <= '0;
                    bus.write_byte      <= BLANK;
                    state               <= CLEAR_LINE;
                  end
                end
                8'h08: begin
                  if (bus.cursor_col != '0) begin
                    bus.cursor_col <= bus.cursor_col - COL_BITS'(1);
                  end
                end
                8'h09: bus.cursor_col <= tab_col_c;
                default: ;
              endcase
            end
          end
        end

        WRITE: begin
          if (bus.write_ready) begin
            bus.write_valid <= 1'b0;
            if (bus.cursor_col == COL_LAST) begin
              bus.cursor_col <= '0;
              if (bus.cursor_row != ROW_LAST) begin
                bus.cursor_row      <= bus.cursor_row + ROW_BITS'(1);
                bus.character_ready <= 1'b1;
                state               <= IDLE;
              end else begin
                // Wrap on the bottom line: glyph is done, now scroll.
                bus.top_row     <= top_next_c;
                bus.write_valid <= 1'b1;
                bus.write_row   <= bus.top_row;
                bus.write_col   <= '0;
                bus.write_byte  <= BLANK;
                state           <= CLEAR_LINE;
              end
            end else begin
              bus.cursor_col      <= bus.cursor_col + COL_BITS'(1);
              bus.character_ready <= 1'b1;
              state               <= IDLE;
            end
          end
        end

        CLEAR_LINE: begin
          if (bus.write_ready) begin
            if (bus.write_col == COL_LAST) begin
              bus.write_valid     <= 1'b0;
              bus.character_ready <= 1'b1;
              state               <= IDLE;
            end else begin
              bus.write_col <= bus.write_col + COL_BITS'(1);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_terminal_writer.sv
// Bench for terminal_writer: directed steps followed by a random character
// stream, checked against a screen/cursor model kept in the bench.
module tb_terminal_writer;

  localparam int ROWS = 4;
  localparam int COLS = 8;
  localparam int RB   = 3;
  localparam int CB   = 4;
  localparam int TABW = 8;
  localparam logic [7:0] BLANK = 8'h20;

  logic clk = 1'b0;
  logic reset;
  logic wr_rdy = 1'b1;
  int   stall_mode = 0;

  int checks = 0;
  int errors = 0;

  int m_top, m_row, m_col;
  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];
  logic        held = 1'b0;
  logic [31:0] held_val;

  always #5 clk = ~clk;

  terminal_writer_if #(.ROW_BITS(RB), .COL_BITS(CB)) bus ();

  assign bus.write_ready = wr_rdy;

  terminal_writer #(
    .ROWS(ROWS), .COLS(COLS), .ROW_BITS(RB), .COL_BITS(CB),
    .TAB_WIDTH(TABW), .BLANK(BLANK)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  function automatic logic [31:0] pack_w(input int r, input int c, input logic [7:0] b);
    return (32'(r) << 16) | (32'(c) << 8) | 32'(b);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, want);
    end
  endtask

  // VRAM back-pressure: always ready, always stalled, or random.
  always @(posedge clk) begin
    #2;
    case (stall_mode)
      0:       wr_rdy = 1'b1;
      1:       wr_rdy = 1'b0;
      default: wr_rdy = ($urandom_range(3) != 0);
    endcase
  end

  // Write monitor: logs handshakes and checks stability while stalled.
  always @(negedge clk) begin
    if (reset) begin
      held = 1'b0;
    end else begin
      if (held) begin
        chk("hold_valid", 32'(bus.write_valid), 32'd1);
        chk("hold_data", pack_w(int'(bus.write_row), int'(bus.write_col), bus.write_byte), held_val);
      end
      held     = bus.write_valid && !bus.write_ready;
      held_val = pack_w(int'(bus.write_row), int'(bus.write_col), bus.write_byte);
      if (bus.write_valid && bus.write_ready)
        obs_q.push_back(pack_w(int'(bus.write_row), int'(bus.write_col), bus.write_byte));
    end
  end

  // Reference model: screen rules applied directly.
  task automatic m_reset();
    m_top = 0; m_row = 0; m_col = 0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) exp_q.push_back(pack_w(r, c, BLANK));
  endtask

  task automatic m_newline();
    if (m_row < ROWS - 1) m_row++;
    else begin
      for (int c = 0; c < COLS; c++) exp_q.push_back(pack_w(m_top, c, BLANK));
      m_top = (m_top + 1) % ROWS;
    end
  endtask

  task automatic m_char(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      exp_q.push_back(pack_w((m_top + m_row) % ROWS, m_col, b));
      m_col++;
      if (m_col == COLS) begin
        m_col = 0;
        m_newline();
      end
    end else if (b == 8'h0D) m_col = 0;
    else if (b == 8'h0A) m_newline();
    else if (b == 8'h08) begin
      if (m_col > 0) m_col--;
    end else if (b == 8'h09) begin
      m_col = (m_col / TABW + 1) * TABW;
      if (m_col > COLS - 1) m_col = COLS - 1;
    end
  endtask

  // Counts negedges until character_ready (bounded).
  task automatic wait_ready(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (bus.character_ready !== 1'b1 && cyc < 3000);
    chk("ready_reached", 32'(bus.character_ready), 32'd1);
  endtask

  // Offers one byte at a negedge; returns accept-to-ready latency if waited.
  task automatic send(input logic [7:0] b, input bit wait_done, output int lat);
    int n = 0;
    while (bus.character_ready !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", 32'(bus.character_ready), 32'd1);
    bus.character_valid = 1'b1;
    bus.character_byte  = b;
    @(posedge clk);
    m_char(b);
    #1 bus.character_valid = 1'b0;
    lat = 0;
    if (wait_done) wait_ready(lat);
    else @(negedge clk);
  endtask

  task automatic check_state(input string tag);
    int n;
    chk({tag, "_cursor_row"}, 32'(bus.cursor_row), 32'(m_row));
    chk({tag, "_cursor_col"}, 32'(bus.cursor_col), 32'(m_col));
    chk({tag, "_top_row"},    32'(bus.top_row),    32'(m_top));
    chk({tag, "_write_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({tag, "_write"}, obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    logic [7:0] b;
    int r;

    reset = 1'b1;
    bus.character_valid = 1'b0;
    bus.character_byte  = 8'h00;
    #12;
    chk("rst_ready",  32'(bus.character_ready), 32'd0);
    chk("rst_valid",  32'(bus.write_valid), 32'd0);
    chk("rst_wpos",   pack_w(int'(bus.write_row), int'(bus.write_col), bus.write_byte), pack_w(0, 0, BLANK));
    chk("rst_top",    32'(bus.top_row), 32'd0);
    chk("rst_cursor", pack_w(int'(bus.cursor_row), int'(bus.cursor_col), 8'h00), pack_w(0, 0, 8'h00));

    // Power-on clear.
    @(negedge clk);
    reset = 1'b0;
    m_reset();
    @(negedge clk);
    chk("clr_first_valid", 32'(bus.write_valid), 32'd1);
    chk("clr_first_pos", pack_w(int'(bus.write_row), int'(bus.write_col), bus.write_byte), pack_w(0, 0, BLANK));
    wait_ready(lat);
    check_state("clear_all");

    // 'A' with the no-wrap latency, then 'B' under a VRAM stall.
    send(8'h41, 1'b1, lat);
    chk("lat_printable", 32'(lat), 32'd2);
    stall_mode = 1;
    @(negedge clk);
    send(8'h42, 1'b0, lat);
    bus.character_valid = 1'b1;
    bus.character_byte  = 8'h51;
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", 32'(bus.write_valid), 32'd1);
      chk("stall_data", pack_w(int'(bus.write_row), int'(bus.write_col), bus.write_byte), pack_w(0, 1, 8'h42));
      chk("stall_not_ready", 32'(bus.character_ready), 32'd0);
      @(negedge clk);
    end
    bus.character_valid = 1'b0;
    stall_mode = 0;
    wait_ready(lat);
    check_state("ab");

    // Cursor-only controls.
    send(8'h09, 1'b1, lat); chk("lat_tab", 32'(lat), 32'd1); check_state("tab_cap");
    send(8'h08, 1'b1, lat); check_state("bs");
    send(8'h0D, 1'b1, lat); check_state("cr");
    send(8'h08, 1'b1, lat); check_state("bs_at_0");

    // Down to the bottom row, then four scrolling line feeds.
    for (int i = 0; i < 3; i++) begin
      send(8'h0A, 1'b1, lat);
      chk("lat_lf", 32'(lat), 32'd1);
    end
    check_state("lf_down");
    for (int i = 0; i < 4; i++) begin
      send(8'h0A, 1'b1, lat);
      chk("lat_scroll", 32'(lat), 32'(COLS + 1));
      check_state("lf_scroll");
    end

    // Glyph in the bottom-right cell wraps and scrolls.
    send(8'h09, 1'b1, lat);
    check_state("tab_to_end");
    send(8'h5A, 1'b1, lat);
    chk("lat_wrap_scroll", 32'(lat), 32'(COLS + 2));
    check_state("wrap_scroll");

    // Reset while a line clear is in progress.
    send(8'h0A, 1'b0, lat);
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midreset_valid", 32'(bus.write_valid), 32'd0);
    chk("midreset_ready", 32'(bus.character_ready), 32'd0);
    obs_q.delete();
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    m_reset();
    @(negedge clk);
    chk("reclr_first_pos", pack_w(int'(bus.write_row), int'(bus.write_col), bus.write_byte), pack_w(0, 0, BLANK));
    chk("reclr_top", 32'(bus.top_row), 32'd0);
    wait_ready(lat);
    check_state("reclear");

    // Random traffic with random back-pressure.
    stall_mode = 2;
    for (int i = 0; i < 200; i++) begin
      r = int'($urandom_range(99));
      if (r < 55)      b = 8'($urandom_range(8'h7E, 8'h20));
      else if (r < 65) b = 8'h0A;
      else if (r < 72) b = 8'h0D;
      else if (r < 80) b = 8'h08;
      else if (r < 88) b = 8'h09;
      else             b = 8'($urandom_range(255));
      send(b, 1'b1, lat);
      check_state("random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
